// File: rtl/aes_data_out_fifo_if.sv
// AES output FIFO bus: producer request/ack side plus
// consumer valid/ready side, grouped for one port.
interface aes_data_out_fifo_if #(
  parameter int DATA_W = 128,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_CH-1:0]        inWr;
  logic [NUM_CH*DATA_W-1:0] inData;
  logic [NUM_CH-1:0]        outWrAck;
  logic                     outValid;
  logic [DATA_W-1:0]        outData;
  logic [CH_W-1:0]          outCh;
  logic                     inRdy;
  logic [CNT_W-1:0]         outCount;

  modport master (
    output inWr, inData, inRdy,
    input  outWrAck, outValid, outData, outCh, outCount
  );

  modport slave (
    input  inWr, inData, inRdy,
    output outWrAck, outValid, outData, outCh, outCount
  );
endinterface

// File: rtl/aes_data_out_fifo.sv
// AES output stage: arbitrates producer channels into a
// tagged first-word-fall-through FIFO with valid/ready out.
module aes_data_out_fifo #(
  parameter int DATA_W    = 128,
  parameter int NUM_CH    = 2,
  parameter int DEPTH     = 4,
  parameter int PRIO_MODE = 0
) (
  input logic inClk,
  input logic inRstN,
  aes_data_out_fifo_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  count;
  logic [CH_W-1:0]   rrPtr;
  logic [CH_W-1:0]   rrNext;
  logic [CH_W-1:0]   gntIdx;
  logic [NUM_CH-1:0] gnt;
  logic              gntAny;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;

  logic [DATA_W-1:0] memData [DEPTH];
  logic [CH_W-1:0]   memCh   [DEPTH];

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = gntAny;
  assign pop   = !empty && bus.inRdy;

  // Pick one requester; a full queue or reset blocks all grants.
  always_comb begin : grantSel
    int idx;
    gnt    = '0;
    gntIdx = '0;
    gntAny = 1'b0;
    idx    = 0;
    if (inRstN && !full) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (PRIO_MODE == 1) begin
          idx = (int'(rrPtr) + k) % NUM_CH;
        end else begin
          idx = k;
        end
        if (!gntAny && bus.inWr[idx]) begin
          gntAny = 1'b1;
          gntIdx = CH_W'(idx);
        end
      end
      if (gntAny) begin
        gnt[gntIdx] = 1'b1;
      end
    end
  end

  assign rrNext = (int'(gntIdx) == NUM_CH - 1)
                ? '0 : gntIdx + 1'b1;

  // Pointers, occupancy and round-robin position.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      rrPtr <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (PRIO_MODE == 1 && push) begin
        rrPtr <= rrNext;
      end
    end
  end

  // Storage is unreset; empty entries are masked at the output.
  always_ff @(posedge inClk) begin
    if (push) begin
      memData[wrPtr] <=
        bus.inData[int'(gntIdx)*DATA_W +: DATA_W];
      memCh[wrPtr]   <= gntIdx;
    end
  end

  assign bus.outWrAck = gnt;
  assign bus.outValid = !empty;
  assign bus.outData  = empty ? '0 : memData[rdPtr];
  assign bus.outCh    = empty ? '0 : memCh[rdPtr];
  assign bus.outCount = count;
endmodule

// File: doc/aes_data_out_fifo.md
Name: aes_data_out_fifo

Overview:
- Parametrised output stage for the AES encrypt/decrypt datapath.
- Accepts result blocks from NUM_CH producer channels (channel 0 = encrypt core, 1 = decrypt core in the default build), arbitrates between them, and queues each block with its channel tag in a DEPTH-entry first-word-fall-through FIFO.
- Presents the queue to the downstream consumer with a valid/ready handshake.
- Replaces the single-entry, fixed-priority output register; adds back-pressure, buffering and selectable arbitration.

Parameters:
- DATA_W, 128: width of one data block.
- NUM_CH, 2: number of producer channels, 1..8.
- DEPTH, 4: FIFO entries; power of 2, ≥2.
- PRIO_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- CH_W, clog2(NUM_CH) (min 1): width of the channel tag. Derived; not overridable.

Ports:
- inClk  input  1  clock, all state on rising edge.
- inRstN  input  1  asynchronous active-low reset.
- inWr  input  NUM_CH  per-channel write request; held until acknowledged.
- inData  input  NUM_CH*DATA_W  channel i data at bits [i*DATA_W +: DATA_W].
- outWrAck  output  NUM_CH  one-hot grant; write of channel i completes on the edge where outWrAck[i]=1.
- outValid  output  1  FIFO head valid.
- outData  output  DATA_W  head data; 0 when empty.
- outCh  output  CH_W  head channel tag; 0 when empty.
- inRdy  input  1  consumer ready; pop on an edge where outValid && inRdy.
- outCount  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (inRstN=0, asynchronous):
  - wrPtr, rdPtr, count and round-robin pointer = 0.
  - outValid=0, outData=0, outCh=0, outWrAck=0, outCount=0.
  - Storage array is not reset; it is masked by outValid.
  - Reset mid-operation discards all queued entries and any pending grant.
- Grant (combinational):
  - outWrAck is nonzero only when count<DEPTH and some inWr bit is set.
  - Full FIFO: no grant, even if a pop happens the same cycle. There is no inRdy→outWrAck path.
  - PRIO_MODE=0: grant the lowest-index requesting channel.
  - PRIO_MODE=1: grant the first requester at or after rrPtr, wrapping NUM_CH-1→0. After a grant to channel g, rrPtr ← (g+1) mod NUM_CH. rrPtr is unchanged when there is no grant.
  - outWrAck never depends on inData.
- Push: on a grant edge, mem[wrPtr] ← {g, channel g data} and wrPtr ← wrPtr+1 mod DEPTH.
- Pop: on an edge with outValid && inRdy, rdPtr ← rdPtr+1 mod DEPTH.
- Count: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop (legal whenever 0<count<DEPTH).
- Output:
  - outValid = (count≠0).
  - outData and outCh are taken from mem[rdPtr], forced to 0 when empty.
  - Latency is 1 cycle: data pushed at edge N is visible at the head after edge N if the FIFO was empty.
  - Head data stays stable while outValid && !inRdy.
- Ordering:
  - Entries pop in push order.
  - A channel holding inWr without a grant keeps its data stable. Dropping inWr before the grant is permitted; no write occurs.
- Wrap-around: pointers wrap silently. Full is count==DEPTH; empty is count==0.
- No overflow or underflow is possible by construction. A pop attempt when empty is ignored.

Test Plan:
- Single write: reset; inWr=01, ch0 data=0x0011…EEFF, inRdy=0 → outWrAck=01 for 1 cycle; next cycle outValid=1, outData=0x0011…EEFF, outCh=0, outCount=1; raise inRdy → outValid=0, outData=0.
- Fixed priority: PRIO_MODE=0, inWr=11 held, inRdy=0 → grants 01,01,01,01, then none once full. FIFO holds 4 ch0 entries, outCount=4, ch1 still waiting; one pop → next grant goes to ch0 again.
- Round-robin: PRIO_MODE=1, inWr=11 held, inRdy=1 → grant sequence 01,10,01,10; popped outCh sequence 0,1,0,1.
- Full plus simultaneous pop: fill to 4 entries, then inRdy=1 with inWr=01 → first cycle pop only, no grant; following cycles push and pop together, outCount stays at 3.
- Wrap-around: push 10 blocks of values 1..10 through DEPTH=4 with random inRdy stalls → popped data exactly 1..10 in order; head stable during stalls.
- Async reset: assert inRstN=0 mid-stream with outCount=3 and no clock edge → outValid, outData, outCount and outWrAck drop to 0 immediately; after release, the first write appears at the head with outCh matching its channel.
